// File: rtl/aud_dsp_bus_dma_pkg.sv
// Shared types for the DSP bus DMA: FSM states, transfer modes, and the
// word stride helper.
package aud_dsp_dma_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      FIN     = 3'd4
   } dma_state_t;

   typedef enum logic {
      COPY = 1'b0,
      FILL = 1'b1
   } dma_mode_t;

   localparam int WORD_BYTES = 4;

   // Wraps modulo 2**32 by construction.
   function automatic logic [31:0] next_word(input logic [31:0] addr);
      return addr + 32'(WORD_BYTES);
   endfunction

endpackage

// File: rtl/aud_dsp_bus_dma_if.sv
// DSP host request bus: one request channel plus a read-response channel.
interface aud_dsp_bus_dma_if;
   logic [31:0] h_addr;
   logic        h_req_vld;
   logic        h_req_rdy;
   logic        h_we;
   logic [3:0]  h_wbe;
   logic [31:0] h_wdata;
   logic [31:0] h_rdata;
   logic        h_vld;

   modport master (
      output h_addr, h_req_vld, h_we, h_wbe, h_wdata,
      input  h_req_rdy, h_rdata, h_vld
   );

   modport slave (
      input  h_addr, h_req_vld, h_we, h_wbe, h_wdata,
      output h_req_rdy, h_rdata, h_vld
   );
endinterface

// File: rtl/aud_dsp_bus_dma_wdog.sv
// Read-response watchdog: saturating counter with clear/load/enable that
// flags the cycle on which the TIMEOUT_CYC-th enabled cycle is reached.
module aud_dsp_bus_wdog #(
   parameter int TO_W        = 8,
   parameter int TIMEOUT_CYC = 200
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            load,
   input  logic [TO_W-1:0] load_val,
   input  logic            en,
   output logic            timeout
);

   localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] cnt_reg;
   logic            at_limit;

   assign at_limit = (cnt_reg >= LAST_CNT);
   // Counter holds the number of already-completed waiting cycles, so the
   // flag rises during the TIMEOUT_CYC-th cycle itself.
   assign timeout  = en && at_limit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (en && !at_limit) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/aud_dsp_bus_dma.sv
// Single-channel DSP bus DMA initiator: word copy (read then write) or
// constant fill between memory regions, with abort and read watchdog.
module aud_dsp_bus_dma
   import aud_dsp_dma_pkg::*;
#(
   parameter int LEN_W       = 12,
   parameter int TO_W        = 8,
   parameter int TIMEOUT_CYC = 200
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_start,
   input  logic             cfg_abort,
   input  logic             cfg_mode,
   input  logic [31:0]      cfg_src_addr,
   input  logic [31:0]      cfg_dst_addr,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [31:0]      cfg_fill_data,
   input  logic [3:0]       cfg_wbe,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             aborted,
   output logic [LEN_W-1:0] xfer_cnt,
   aud_dsp_bus_dma_if.master bus
);

   dma_state_t       state_reg;
   dma_mode_t        mode_reg;
   logic [31:0]      src_reg;
   logic [31:0]      dst_reg;
   logic [LEN_W-1:0] remain_reg;
   logic [31:0]      fill_reg;
   logic [3:0]       wbe_reg;
   logic             abort_pend_reg;

   logic [31:0]      h_addr_reg;
   logic             h_req_vld_reg;
   logic             h_we_reg;
   logic [3:0]       h_wbe_reg;
   logic [31:0]      h_wdata_reg;

   logic             wdog_timeout;
   logic             stop_now;

   assign bus.h_addr    = h_addr_reg;
   assign bus.h_req_vld = h_req_vld_reg;
   assign bus.h_we      = h_we_reg;
   assign bus.h_wbe     = h_wbe_reg;
   assign bus.h_wdata   = h_wdata_reg;

   // Stop after the current write if this was the last word or an abort
   // is pending (including one arriving in the handshake cycle itself).
   assign stop_now = (remain_reg == LEN_W'(1)) || abort_pend_reg || cfg_abort;

   aud_dsp_bus_wdog #(
      .TO_W        (TO_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (state_reg != RD_WAIT),
      .load     (1'b0),
      .load_val ('0),
      .en       (state_reg == RD_WAIT),
      .timeout  (wdog_timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         mode_reg       <= COPY;
         src_reg        <= '0;
         dst_reg        <= '0;
         remain_reg     <= '0;
         fill_reg       <= '0;
         wbe_reg        <= '0;
         abort_pend_reg <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         aborted        <= 1'b0;
         xfer_cnt       <= '0;
         h_addr_reg     <= '0;
         h_req_vld_reg  <= 1'b0;
         h_we_reg       <= 1'b0;
         h_wbe_reg      <= '0;
         h_wdata_reg    <= '0;
      end else begin
         done <= 1'b0;
         if (cfg_abort && (state_reg inside {RD_REQ, RD_WAIT, WR_REQ})) begin
            abort_pend_reg <= 1'b1;
         end

         case (state_reg)
            IDLE: begin
               if (cfg_start) begin
                  mode_reg       <= dma_mode_t'(cfg_mode);
                  src_reg        <= {cfg_src_addr[31:2], 2'b00};
                  dst_reg        <= {cfg_dst_addr[31:2], 2'b00};
                  remain_reg     <= cfg_len;
                  fill_reg       <= cfg_fill_data;
                  wbe_reg        <= cfg_wbe;
                  err            <= 1'b0;
                  aborted        <= 1'b0;
                  xfer_cnt       <= '0;
                  abort_pend_reg <= 1'b0;
                  if (cfg_len == '0) begin
                     done      <= 1'b1;
                     state_reg <= FIN;
                  end else if (cfg_mode == FILL) begin
                     busy          <= 1'b1;
                     state_reg     <= WR_REQ;
                     h_req_vld_reg <= 1'b1;
                     h_we_reg      <= 1'b1;
                     h_addr_reg    <= {cfg_dst_addr[31:2], 2'b00};
                     h_wbe_reg     <= cfg_wbe;
                     h_wdata_reg   <= cfg_fill_data;
                  end else begin
                     busy          <= 1'b1;
                     state_reg     <= RD_REQ;
                     h_req_vld_reg <= 1'b1;
                     h_we_reg      <= 1'b0;
                     h_addr_reg    <= {cfg_src_addr[31:2], 2'b00};
                     h_wbe_reg     <= '0;
                  end
               end
            end

            RD_REQ: begin
               if (bus.h_req_rdy) begin
                  h_req_vld_reg <= 1'b0;
                  src_reg       <= next_word(src_reg);
                  state_reg     <= RD_WAIT;
               end
            end

            RD_WAIT: begin
               if (bus.h_vld) begin
                  state_reg     <= WR_REQ;
                  h_req_vld_reg <= 1'b1;
                  h_we_reg      <= 1'b1;
                  h_addr_reg    <= dst_reg;
                  h_wbe_reg     <= wbe_reg;
                  h_wdata_reg   <= bus.h_rdata;
               end else if (wdog_timeout) begin
                  err       <= 1'b1;
                  aborted   <= abort_pend_reg || cfg_abort;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_reg <= FIN;
               end
            end

            WR_REQ: begin
               if (bus.h_req_rdy) begin
                  dst_reg    <= next_word(dst_reg);
                  xfer_cnt   <= xfer_cnt + 1'b1;
                  remain_reg <= remain_reg - 1'b1;
                  if (stop_now) begin
                     h_req_vld_reg <= 1'b0;
                     h_we_reg      <= 1'b0;
                     h_wbe_reg     <= '0;
                     aborted       <= abort_pend_reg || cfg_abort;
                     busy          <= 1'b0;
                     done          <= 1'b1;
                     state_reg     <= FIN;
                  end else if (mode_reg == FILL) begin
                     h_addr_reg <= next_word(dst_reg);
                  end else begin
                     h_we_reg   <= 1'b0;
                     h_wbe_reg  <= '0;
                     h_addr_reg <= src_reg;
                     state_reg  <= RD_REQ;
                  end
               end
            end

            FIN: begin
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
